// File: rtl/btn_conditioner_if.sv
// Push-button conditioner bus.
//   btn_raw    : raw active-low buttons, driven by the board side (master)
//   btn_evt    : active-low one-cycle press events, 4'b1111 = no event
//   btn_stable : debounced active-low button levels
//   any_held   : high while any debounced button is pressed
//   sec_tick   : one-cycle pulse per second (0 unless SEC_TICK_EN is built in)
// The master modport belongs to whoever drives the buttons.
// The slave modport belongs to the conditioner.
interface btn_conditioner_if;
  logic [3:0] btn_raw;
  logic [3:0] btn_evt;
  logic [3:0] btn_stable;
  logic       any_held;
  logic       sec_tick;

  modport master (
    output btn_raw,
    input  btn_evt, btn_stable, any_held, sec_tick
  );

  modport slave (
    input  btn_raw,
    output btn_evt, btn_stable, any_held, sec_tick
  );
endinterface

// File: rtl/btn_conditioner.sv
// Four-button debouncer and press-event generator.
// Each raw button is first synchronized through two flops.
// It is then debounced by its own RELEASED / PRESS_WAIT / PRESSED /
// RELEASE_WAIT state machine. The new level must stay steady for
// DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS cycles before it is accepted.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   btn_if : btn_conditioner_if.slave
//            (btn_raw in; btn_evt, btn_stable, any_held, sec_tick out)
// Build option: define SEC_TICK_EN to add a free-running second counter
// that pulses sec_tick. Without it, sec_tick is tied to 0.
module btn_conditioner #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic             clk,
  input  logic             rst,
  btn_conditioner_if.slave btn_if
);

  localparam int               DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int               CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_CNT    = CNT_W'(DB_CYCLES);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  logic [3:0]       r_sync_p0;
  logic [3:0]       r_sync_p1;
  state_t           r_state     [4];
  state_t           w_state_nxt [4];
  logic [CNT_W-1:0] r_cnt       [4];
  logic [CNT_W-1:0] w_cnt_nxt   [4];
  logic [3:0]       w_press;
  logic [3:0]       w_stable_nxt;
  logic [3:0]       r_evt;
  logic [3:0]       r_stable;
  logic             r_any_held;

  // The counter holds at DB_CNT rather than wrapping, whatever the state.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= DB_CNT) ? DB_CNT : v + CNT_W'(1);
  endfunction

  // ---- stage p0/p1: two-flop synchronizer; it resets to "released" ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 4'hF;
      r_sync_p1 <= 4'hF;
    end else begin
      r_sync_p0 <= btn_if.btn_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- debounce state machines: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_RELEASED;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state logic.
  // The first cycle at a new level moves the FSM into a WAIT state.
  // The counter then counts further steady cycles.
  // The transition happens on the cycle that finds the counter at DB_CNT.
  always_comb begin
    w_press      = 4'b0000;
    w_stable_nxt = 4'hF;
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_RELEASED: begin
          w_cnt_nxt[i] = '0;
          if (!r_sync_p1[i]) w_state_nxt[i] = ST_PRESS_WAIT;
        end
        ST_PRESS_WAIT: begin
          if (r_sync_p1[i]) begin
            w_state_nxt[i] = ST_RELEASED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DB_CNT) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = '0;
            w_press[i]     = 1'b1;
          end else begin
            w_cnt_nxt[i] = sat_inc(r_cnt[i]);
          end
        end
        ST_PRESSED: begin
          w_cnt_nxt[i] = '0;
          if (r_sync_p1[i]) w_state_nxt[i] = ST_RELEASE_WAIT;
        end
        ST_RELEASE_WAIT: begin
          if (!r_sync_p1[i]) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DB_CNT) begin
            w_state_nxt[i] = ST_RELEASED;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = sat_inc(r_cnt[i]);
          end
        end
        default: begin
          w_state_nxt[i] = ST_RELEASED;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_stable_nxt[i] = !((w_state_nxt[i] == ST_PRESSED) ||
                          (w_state_nxt[i] == ST_RELEASE_WAIT));
    end
  end

  // ---- output registers ----
  // The outputs are registered from the next state.
  // btn_stable and any_held therefore change on the same edge as the state.
  // The press event appears in the first cycle spent in PRESSED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt      <= 4'hF;
      r_stable   <= 4'hF;
      r_any_held <= 1'b0;
    end else begin
      r_evt      <= ~w_press;
      r_stable   <= w_stable_nxt;
      r_any_held <= ~&w_stable_nxt;
    end
  end

  assign btn_if.btn_evt    = r_evt;
  assign btn_if.btn_stable = r_stable;
  assign btn_if.any_held   = r_any_held;

`ifdef SEC_TICK_EN
  localparam int               SEC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);

  logic [SEC_W-1:0] r_sec_cnt;
  logic             r_sec_tick;

  // ---- second counter: counts 0..CLK_HZ-1, pulsing as it wraps ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_cnt  <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= (r_sec_cnt == SEC_LAST);
      r_sec_cnt  <= (r_sec_cnt == SEC_LAST) ? '0 : r_sec_cnt + SEC_W'(1);
    end
  end

  assign btn_if.sec_tick = r_sec_tick;
`else
  assign btn_if.sec_tick = 1'b0;
`endif

endmodule
